// File: rtl/booth_product_accumulator.sv
// Group accumulator behind the radix-8 Booth multiplier of a systolic PE.
// Sums K signed products per group and parks the result in a valid/ready register.
module booth_product_accumulator #(
   parameter int N        = 8,
   parameter int ACC_W    = 24,
   parameter int K        = 3,
   parameter int SATURATE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2*N-1:0]             in_prod,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ACC_W-1:0]           out_sum,
   output logic [$clog2(K+1)-1:0]     out_count,
   output logic                       out_ovf,
   output logic                       out_err
);

   localparam int CW = $clog2(K+1);
   localparam logic [CW-1:0] LASTC = CW'(K-1);
   localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {ACCUM, STALL} state_t;

   state_t state, state_d;

   logic signed [ACC_W-1:0] acc;
   logic [CW-1:0]           cnt;
   logic                    ovf;
   logic                    err_hold;

   logic signed [2*N-1:0]   prod_s;
   logic signed [ACC_W:0]   acc_x, prod_x, sum_x;
   logic signed [ACC_W-1:0] res;
   logic                    ovf_now, is_k, err_now, out_hs, out_free;
   logic                    load_new, load_held, park, step;
   logic [CW-1:0]           cnt_nx;

   // Sum one bit wider than the accumulator so the overflow is visible.
   assign prod_s  = in_prod;
   assign acc_x   = acc;
   assign prod_x  = prod_s;
   assign sum_x   = acc_x + prod_x;
   assign ovf_now = sum_x[ACC_W] ^ sum_x[ACC_W-1];
   assign is_k    = (cnt == LASTC);
   assign err_now = in_last ^ is_k;
   assign cnt_nx  = cnt + CW'(1);

   assign out_hs   = out_valid & out_ready;
   assign out_free = ~out_valid | out_ready;

   always_comb begin
      res = sum_x[ACC_W-1:0];
      if (ovf_now && SATURATE != 0)
         res = sum_x[ACC_W] ? SMIN : SMAX;
   end

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      load_new  = 1'b0;
      load_held = 1'b0;
      park      = 1'b0;
      step      = 1'b0;
      unique case (state)
         ACCUM: begin
            in_ready = reset;
            if (in_valid && reset) begin
               if (in_last || is_k) begin
                  if (out_free) begin
                     load_new = 1'b1;
                  end else begin
                     park    = 1'b1;
                     state_d = STALL;
                  end
               end else begin
                  step = 1'b1;
               end
            end
         end
         STALL: begin
            if (out_hs) begin
               load_held = 1'b1;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ACCUM;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         cnt      <= '0;
         ovf      <= 1'b0;
         err_hold <= 1'b0;
      end else if (load_new || load_held) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (step || park) begin
         acc <= res;
         cnt <= cnt_nx;
         ovf <= ovf | ovf_now;
         if (park) err_hold <= err_now;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (load_new) begin
         out_valid <= 1'b1;
         out_sum   <= res;
         out_count <= cnt_nx;
         out_ovf   <= ovf | ovf_now;
         out_err   <= err_now;
      end else if (load_held) begin
         out_valid <= 1'b1;
         out_sum   <= acc;
         out_count <= cnt;
         out_ovf   <= ovf;
         out_err   <= err_hold;
      end else if (out_hs) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator (K=3), plus two
// 16-bit accumulator variants for saturate and wrap behaviour.
module tb_booth_product_accumulator;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [15:0] in_prod = '0;
   logic        in_ready, out_valid, out_ovf, out_err;
   logic [23:0] out_sum;
   logic [1:0]  out_count;

   logic        v16 = 1'b0, l16 = 1'b0, r16 = 1'b0;
   logic [15:0] p16 = '0;
   logic        s_ir, s_ov, s_of, s_er, w_ir, w_ov, w_of, w_er;
   logic [15:0] s_sum, w_sum;
   logic [1:0]  s_cnt, w_cnt;

   int total = 0;
   int passed = 0;
   int waits = 0;

   always #5 clk = ~clk;

   booth_product_accumulator #(.N(8), .ACC_W(24), .K(3), .SATURATE(1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count),
      .out_ovf(out_ovf), .out_err(out_err)
   );

   booth_product_accumulator #(.N(8), .ACC_W(16), .K(3), .SATURATE(1)) dut_s (
      .clk(clk), .reset(reset),
      .in_valid(v16), .in_ready(s_ir),
      .in_prod(p16), .in_last(l16),
      .out_valid(s_ov), .out_ready(r16),
      .out_sum(s_sum), .out_count(s_cnt),
      .out_ovf(s_of), .out_err(s_er)
   );

   booth_product_accumulator #(.N(8), .ACC_W(16), .K(3), .SATURATE(0)) dut_w (
      .clk(clk), .reset(reset),
      .in_valid(v16), .in_ready(w_ir),
      .in_prod(p16), .in_last(l16),
      .out_valid(w_ov), .out_ready(r16),
      .out_sum(w_sum), .out_count(w_cnt),
      .out_ovf(w_of), .out_err(w_er)
   );

   task automatic send(input logic [15:0] p, input logic l);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      waits += w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (in_ready !== 1'b0) $display("FAIL rst_in_ready: %b required 0", in_ready);
      else passed++;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: %b required 0", out_valid);
      else passed++;
      total++;
      if (out_sum !== 24'd0 || out_count !== 2'd0)
         $display("FAIL rst_sum_count: %0d/%0d required 0/0", out_sum, out_count);
      else passed++;
      total++;
      if (out_ovf !== 1'b0 || out_err !== 1'b0)
         $display("FAIL rst_flags: %b%b required 00", out_ovf, out_err);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL rst_release_ready: %b required 1", in_ready);
      else passed++;
   endtask

   task automatic test_basic();
      send(16'd100, 1'b0);
      send(-16'sd50, 1'b0);
      total++;
      if (out_valid !== 1'b0) $display("FAIL basic_early_valid: %b required 0", out_valid);
      else passed++;
      send(16'd7, 1'b1);
      total++;
      if (out_valid !== 1'b1) $display("FAIL basic_latency: %b required 1", out_valid);
      else passed++;
      total++;
      if (out_sum !== 24'd57) $display("FAIL basic_sum: %0d required 57", $signed(out_sum));
      else passed++;
      total++;
      if (out_count !== 2'd3 || out_ovf !== 1'b0 || out_err !== 1'b0)
         $display("FAIL basic_flags: cnt=%0d ovf=%b err=%b required 3 0 0",
                  out_count, out_ovf, out_err);
      else passed++;
      drain();
      total++;
      if (out_valid !== 1'b0) $display("FAIL basic_drop: %b required 0", out_valid);
      else passed++;
   endtask

   task automatic test_stall();
      for (int i = 1; i <= 6; i++)
         send(16'(i), (i % 3) == 0);
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall_ready: %b required 0", in_ready);
      else passed++;
      total++;
      if (out_sum !== 24'd6 || out_valid !== 1'b1)
         $display("FAIL stall_first: sum=%0d v=%b required 6 1", out_sum, out_valid);
      else passed++;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (out_sum !== 24'd6 || in_ready !== 1'b0)
         $display("FAIL stall_hold: sum=%0d rdy=%b required 6 0", out_sum, in_ready);
      else passed++;
      drain();
      total++;
      if (out_sum !== 24'd15 || out_valid !== 1'b1 || out_count !== 2'd3)
         $display("FAIL stall_second: sum=%0d v=%b cnt=%0d required 15 1 3",
                  out_sum, out_valid, out_count);
      else passed++;
      total++;
      if (in_ready !== 1'b1) $display("FAIL stall_resume: %b required 1", in_ready);
      else passed++;
      drain();
   endtask

   task automatic test_saturate();
      logic [15:0] vals [3];
      vals[0] = 16'd16384;
      vals[1] = 16'd16384;
      vals[2] = 16'd0;
      for (int i = 0; i < 3; i++) begin
         v16 = 1'b1;
         p16 = vals[i];
         l16 = (i == 2);
         @(posedge clk);
         #1;
      end
      v16 = 1'b0;
      l16 = 1'b0;
      total++;
      if (s_ov !== 1'b1 || s_sum !== 16'h7fff)
         $display("FAIL sat_sum: v=%b sum=%0d required 1 32767", s_ov, $signed(s_sum));
      else passed++;
      total++;
      if (s_of !== 1'b1 || s_cnt !== 2'd3)
         $display("FAIL sat_ovf: ovf=%b cnt=%0d required 1 3", s_of, s_cnt);
      else passed++;
      total++;
      if (w_ov !== 1'b1 || w_sum !== 16'h8000)
         $display("FAIL wrap_sum: v=%b sum=%0d required 1 -32768", w_ov, $signed(w_sum));
      else passed++;
      total++;
      if (w_of !== 1'b1) $display("FAIL wrap_ovf: %b required 1", w_of);
      else passed++;
   endtask

   task automatic test_last_err();
      send(16'd5, 1'b0);
      send(16'd9, 1'b1);
      total++;
      if (out_sum !== 24'd14 || out_count !== 2'd2)
         $display("FAIL early_last: sum=%0d cnt=%0d required 14 2", out_sum, out_count);
      else passed++;
      total++;
      if (out_err !== 1'b1) $display("FAIL early_last_err: %b required 1", out_err);
      else passed++;
      drain();
      send(16'd1, 1'b0);
      send(16'd2, 1'b0);
      send(16'd3, 1'b0);
      total++;
      if (out_sum !== 24'd6 || out_count !== 2'd3)
         $display("FAIL no_last: sum=%0d cnt=%0d required 6 3", out_sum, out_count);
      else passed++;
      total++;
      if (out_err !== 1'b1) $display("FAIL no_last_err: %b required 1", out_err);
      else passed++;
      drain();
   endtask

   task automatic test_mid_reset();
      send(16'd7, 1'b0);
      send(16'd8, 1'b0);
      reset = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 24'd0)
         $display("FAIL midrst_outs: v=%b rdy=%b sum=%0d required 0 0 0",
                  out_valid, in_ready, out_sum);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(16'd1, 1'b0);
      send(16'd1, 1'b0);
      send(16'd1, 1'b1);
      total++;
      if (out_sum !== 24'd3 || out_count !== 2'd3 || out_err !== 1'b0)
         $display("FAIL midrst_group: sum=%0d cnt=%0d err=%b required 3 3 0",
                  out_sum, out_count, out_err);
      else passed++;
      drain();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      waits = 0;
      for (int i = 1; i <= 9; i++) begin
         send(16'd16384, (i % 3) == 0);
         if ((i % 3) == 0) begin
            total++;
            if (out_valid !== 1'b1 || out_sum !== 24'd49152 || out_ovf !== 1'b0)
               $display("FAIL b2b_result%0d: v=%b sum=%0d ovf=%b required 1 49152 0",
                        i / 3, out_valid, out_sum, out_ovf);
            else passed++;
         end
      end
      total++;
      if (waits !== 0) $display("FAIL b2b_ready: stall cycles=%0d required 0", waits);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drain: %b required 0", out_valid);
      else passed++;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_saturate();
      test_last_err();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
